// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
package fifo_pkg;

    // Default instance configuration.
    localparam int DATA_WIDTH = 8;
    localparam int MEM_DEPTH  = 16;
    localparam int AF_LEVEL   = MEM_DEPTH - 2;
    localparam int AE_LEVEL   = 2;

    // Ceiling log2, usable in constant expressions (parameter derivation).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Dual-port storage array: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the write word on the rising edge when the parent grants a write.
    // NOTE: the array has no reset branch; stale words are never observable
    // because the pointers define which entries are live, and leaving it out
    // lets the array map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl_buf.sv
// Synchronous FIFO controller: binary pointers with a wrap bit, derived
// status flags, sticky error flags and a registered read-data stage.
module sync_fifo_ctrl_buf #(
    parameter  int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter  int MEM_DEPTH  = fifo_pkg::MEM_DEPTH,
    parameter  int AF_LEVEL   = MEM_DEPTH - 2,
    parameter  int AE_LEVEL   = fifo_pkg::AE_LEVEL,
    localparam int ADDR_W     = fifo_pkg::clog2(MEM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLR,
    input  logic                  W_INC_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC_EN,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  R_VALID,
    output logic                  W_FULL,
    output logic                  W_ALMOST_FULL,
    output logic                  R_EMPTY,
    output logic                  R_ALMOST_EMPTY,
    output logic [ADDR_W:0]       FIFO_COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam logic [ADDR_W:0] AF_THR = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_THR = AE_LEVEL[ADDR_W:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]       wptr_q, wptr_d;
    logic [ADDR_W:0]       rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  empty;
    logic                  full;
    logic [ADDR_W:0]       count;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                    (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign count  = wptr_q - rptr_q;

    // Full gates writes outright, so a write alongside a read on a full FIFO
    // is rejected even though the read frees a slot on the same edge.
    assign wr_acc = W_INC_EN & ~full;
    assign rd_acc = R_INC_EN & ~empty;

    // Reset and flush both outrank a write, so the array is left untouched.
    assign mem_we = wr_acc & ~CLR & RST_N;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i (WR_DATA),
        .raddr_i (rptr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );

    // Next-state for pointers, read stage and sticky error flags; flush wins.
    // NOTE: every target is given a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (CLR) begin
            wptr_d  = '0;
            rptr_d  = '0;
            rdata_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_acc) begin
                rptr_d   = rptr_q + 1'b1;
                rdata_d  = mem_rdata;
                rvalid_d = 1'b1;
            end
            if (W_INC_EN && full) begin
                ovf_d = 1'b1;
            end
            if (R_INC_EN && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset taking top priority.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Every output comes from a flop or from the registered pointers only.
    assign R_DATA         = rdata_q;
    assign R_VALID        = rvalid_q;
    assign R_EMPTY        = empty;
    assign W_FULL         = full;
    assign FIFO_COUNT     = count;
    assign W_ALMOST_FULL  = (count >= AF_THR);
    assign R_ALMOST_EMPTY = (count <= AE_THR);
    assign OVERFLOW       = ovf_q;
    assign UNDERFLOW      = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl_buf.sv
// Self-checking bench for sync_fifo_ctrl_buf: a constant vector table plus
// hand-written sequences, with a queue model and a read-data scoreboard.
module tb_sync_fifo_ctrl_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          CLR = 1'b0;
    logic          W_INC_EN = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          R_INC_EN = 1'b0;
    logic [DW-1:0] R_DATA;
    logic          R_VALID;
    logic          W_FULL;
    logic          W_ALMOST_FULL;
    logic          R_EMPTY;
    logic          R_ALMOST_EMPTY;
    logic [AW:0]   FIFO_COUNT;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    sync_fifo_ctrl_buf #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .CLR            (CLR),
        .W_INC_EN       (W_INC_EN),
        .WR_DATA        (WR_DATA),
        .R_INC_EN       (R_INC_EN),
        .R_DATA         (R_DATA),
        .R_VALID        (R_VALID),
        .W_FULL         (W_FULL),
        .W_ALMOST_FULL  (W_ALMOST_FULL),
        .R_EMPTY        (R_EMPTY),
        .R_ALMOST_EMPTY (R_ALMOST_EMPTY),
        .FIFO_COUNT     (FIFO_COUNT),
        .OVERFLOW       (OVERFLOW),
        .UNDERFLOW      (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: stored words, sticky flags, and words expected on R_DATA.
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_rd  [$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    typedef struct {
        bit            w;
        bit            r;
        bit            c;
        logic [DW-1:0] d;
        int            count;
        bit            empty;
        bit            full;
        bit            af;
        bit            ae;
        bit            ovf;
        bit            udf;
        bit            rvalid;
        bit            chk_rd;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Drive one clock cycle, advance the model, then compare the post-edge state.
    task automatic cycle(input bit w, input bit r, input bit c, input bit rst, input logic [DW-1:0] d);
        bit            m_full;
        bit            m_empty;
        logic [DW-1:0] exp_v;
        m_full   = (model_q.size() == DEPTH);
        m_empty  = (model_q.size() == 0);
        RST_N    = rst;
        CLR      = c;
        W_INC_EN = w;
        R_INC_EN = r;
        WR_DATA  = d;
        if (!rst || c) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && m_full)   m_ovf = 1'b1;
            if (r && m_empty)  m_udf = 1'b1;
            if (r && !m_empty) exp_rd.push_back(model_q.pop_front());
            if (w && !m_full)  model_q.push_back(d);
        end
        @(posedge CLK);
        #1;
        check("r_valid", R_VALID, exp_rd.size() != 0);
        if (exp_rd.size() != 0) begin
            exp_v = exp_rd.pop_front();
            if (R_VALID) check("r_data", R_DATA, exp_v);
        end
        check("count",    FIFO_COUNT,     model_q.size());
        check("empty",    R_EMPTY,        model_q.size() == 0);
        check("full",     W_FULL,         model_q.size() == DEPTH);
        check("alm_full", W_ALMOST_FULL,  model_q.size() >= AF);
        check("alm_empty",R_ALMOST_EMPTY, model_q.size() <= AE);
        check("overflow", OVERFLOW,       m_ovf);
        check("underflow",UNDERFLOW,      m_udf);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // Table: w, r, clr, data, count, empty, full, af, ae, ovf, udf, rvalid, chk_rd, rdata
        vecs[0] = '{1, 0, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00};
        vecs[1] = '{1, 0, 0, 8'h22, 2, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00};
        vecs[2] = '{1, 0, 0, 8'h33, 3, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00};
        vecs[3] = '{0, 1, 0, 8'h00, 2, 0, 0, 0, 1, 0, 0, 1, 1, 8'h11};
        vecs[4] = '{1, 1, 0, 8'h44, 2, 0, 0, 0, 1, 0, 0, 1, 1, 8'h22};
        vecs[5] = '{0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 1, 8'h33};
        vecs[6] = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 1, 1, 8'h44};
        vecs[7] = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 1, 8'h44};
        vecs[8] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 1, 8'h44};
        vecs[9] = '{1, 0, 1, 8'h55, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00};

        // Reset state.
        do_reset();
        do_reset();
        check("rst_rdata", R_DATA, 8'h00);
        check("rst_count", FIFO_COUNT, 0);
        check("rst_empty", R_EMPTY, 1'b1);
        check("rst_ae",    R_ALMOST_EMPTY, 1'b1);

        // Constant vector table.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].w, vecs[i].r, vecs[i].c, 1'b1, vecs[i].d);
            check($sformatf("v%0d_count", i), FIFO_COUNT, vecs[i].count);
            check($sformatf("v%0d_empty", i), R_EMPTY, vecs[i].empty);
            check($sformatf("v%0d_full", i),  W_FULL, vecs[i].full);
            check($sformatf("v%0d_af", i),    W_ALMOST_FULL, vecs[i].af);
            check($sformatf("v%0d_ae", i),    R_ALMOST_EMPTY, vecs[i].ae);
            check($sformatf("v%0d_ovf", i),   OVERFLOW, vecs[i].ovf);
            check($sformatf("v%0d_udf", i),   UNDERFLOW, vecs[i].udf);
            check($sformatf("v%0d_rvalid", i),R_VALID, vecs[i].rvalid);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), R_DATA, vecs[i].rdata);
        end

        // Fill to full, overflow, then drain in order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'(i));
            if (i == 12) check("af_at_13", W_ALMOST_FULL, 1'b0);
            if (i == 13) check("af_at_14", W_ALMOST_FULL, 1'b1);
        end
        check("fill_full",  W_FULL, 1'b1);
        check("fill_count", FIFO_COUNT, DEPTH);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
        check("ovf_set",   OVERFLOW, 1'b1);
        check("ovf_count", FIFO_COUNT, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
            check($sformatf("drain_%0d", i), R_DATA, 8'(i));
        end
        check("drain_empty", R_EMPTY, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("rvalid_pulse", R_VALID, 1'b0);

        // Streaming read+write across the pointer wrap at constant occupancy.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'hA0 + i));
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'(8'hB0 + i));
            check("stream_count", FIFO_COUNT, 3);
        end
        check("stream_ovf", OVERFLOW, 1'b0);
        check("stream_udf", UNDERFLOW, 1'b0);

        // Read+write on empty: write accepted, read is an underflow.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h5C);
        check("empty_rw_udf",    UNDERFLOW, 1'b1);
        check("empty_rw_count",  FIFO_COUNT, 1);
        check("empty_rw_rvalid", R_VALID, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        check("empty_rw_data", R_DATA, 8'h5C);

        // Read+write on full: read accepted, write is an overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h60 + i));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE);
        check("full_rw_ovf",   OVERFLOW, 1'b1);
        check("full_rw_count", FIFO_COUNT, DEPTH - 1);
        check("full_rw_data",  R_DATA, 8'h60);

        // Flush mid-stream at count 7, with a write in the same cycle.
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h70 + i));
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        check("pre_clr_count", FIFO_COUNT, 7);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h99);
        check("clr_count", FIFO_COUNT, 0);
        check("clr_empty", R_EMPTY, 1'b1);
        check("clr_ovf",   OVERFLOW, 1'b0);
        check("clr_udf",   UNDERFLOW, 1'b0);

        // Same run, with reset instead of flush.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h70 + i));
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        check("pre_rst_count", FIFO_COUNT, 7);
        check("pre_rst_rdata", R_DATA, 8'h70);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        check("rst_mid_count", FIFO_COUNT, 0);
        check("rst_mid_empty", R_EMPTY, 1'b1);
        check("rst_mid_udf",   UNDERFLOW, 1'b0);
        check("rst_mid_rdata", R_DATA, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
